// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: data width, load/store funct3 encodings
// and the memory-stage state type.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE,
      ACCESS
   } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the memory stage: byte enables, replicated store
// data, misalignment detection and sign/zero extension of load data.
module load_store_align
   import riscv_pkg::*;
(
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata,
   output logic            misaligned,
   output logic [XLEN-1:0] load_data
);

   logic [XLEN-1:0] shifted;
   logic            is_unsigned;

   assign shifted     = rdata >> {addr_lo, 3'b000};
   assign is_unsigned = funct3[2];

   always_comb begin
      be         = 4'hF;
      wdata      = store_data;
      misaligned = 1'b0;
      load_data  = shifted;
      case (funct3)
         F3_B, F3_BU: begin
            be        = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
         end
         F3_H, F3_HU: begin
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            wdata      = {2{store_data[15:0]}};
            misaligned = addr_lo[0];
            load_data  = is_unsigned ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
         end
         default: begin
            misaligned = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// Memory stage: accepts one instruction per handshake, runs a single
// outstanding data-memory transaction for loads/stores, retires to write-back.
module memory_access
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] alu_result_from_execution,
   input  logic [XLEN-1:0] read_data_2_from_execution,
   input  logic [4:0]      immed_11_7_from_execution,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   output logic            wb_we,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            misaligned
);

   mem_state_t state_q, state_d;

   logic       accept;
   logic       mem_op;
   logic       is_store;
   logic [1:0] addr_lo_q;
   logic [2:0] funct3_q;
   logic [4:0] rd_q;

   logic [1:0]      al_addr_lo;
   logic [2:0]      al_funct3;
   logic [3:0]      al_be;
   logic [XLEN-1:0] al_wdata;
   logic            al_misaligned;
   logic [XLEN-1:0] al_load_data;

   assign ex_ready = (state_q == IDLE);
   assign accept   = ex_valid && ex_ready;
   assign mem_op   = mem_read || mem_write;
   assign is_store = mem_write && !mem_read;

   // One aligner serves both phases: incoming op while IDLE (be/wdata/misalign),
   // registered op while ACCESS (load extraction).
   assign al_addr_lo = (state_q == IDLE) ? alu_result_from_execution[1:0] : addr_lo_q;
   assign al_funct3  = (state_q == IDLE) ? funct3 : funct3_q;

   load_store_align u_align (
      .addr_lo    (al_addr_lo),
      .funct3     (al_funct3),
      .store_data (read_data_2_from_execution),
      .rdata      (dmem_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .misaligned (al_misaligned),
      .load_data  (al_load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && mem_op && !al_misaligned) state_d = ACCESS;
         ACCESS:  if (dmem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= '0;
         wb_valid   <= 1'b0;
         wb_we      <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         misaligned <= 1'b0;
         addr_lo_q  <= '0;
         funct3_q   <= '0;
         rd_q       <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (!mem_op) begin
                     wb_valid   <= 1'b1;
                     wb_we      <= 1'b1;
                     misaligned <= 1'b0;
                     wb_rd      <= immed_11_7_from_execution;
                     wb_data    <= alu_result_from_execution;
                  end else if (al_misaligned) begin
                     wb_valid   <= 1'b1;
                     wb_we      <= 1'b0;
                     misaligned <= 1'b1;
                     wb_rd      <= immed_11_7_from_execution;
                  end else begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= is_store;
                     dmem_addr  <= {alu_result_from_execution[XLEN-1:2], 2'b00};
                     dmem_wdata <= al_wdata;
                     dmem_be    <= al_be;
                     addr_lo_q  <= alu_result_from_execution[1:0];
                     funct3_q   <= funct3;
                     rd_q       <= immed_11_7_from_execution;
                  end
               end
            end
            ACCESS: begin
               if (dmem_ack) begin
                  dmem_req   <= 1'b0;
                  dmem_we    <= 1'b0;
                  dmem_be    <= '0;
                  wb_valid   <= 1'b1;
                  wb_we      <= !dmem_we;
                  misaligned <= 1'b0;
                  wb_rd      <= rd_q;
                  if (!dmem_we) wb_data <= al_load_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for the memory_access pipeline stage.
module tb_memory_access;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [31:0] alu_result_from_execution = '0;
   logic [31:0] read_data_2_from_execution = '0;
   logic [4:0]  immed_11_7_from_execution = '0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = '0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        wb_valid, wb_we, misaligned;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0;
   int fails  = 0;
   int wb_count = 0;

   memory_access dut (
      .clk                        (clk),
      .rst                        (rst),
      .ex_valid                   (ex_valid),
      .ex_ready                   (ex_ready),
      .alu_result_from_execution  (alu_result_from_execution),
      .read_data_2_from_execution (read_data_2_from_execution),
      .immed_11_7_from_execution  (immed_11_7_from_execution),
      .mem_read                   (mem_read),
      .mem_write                  (mem_write),
      .funct3                     (funct3),
      .dmem_req                   (dmem_req),
      .dmem_we                    (dmem_we),
      .dmem_addr                  (dmem_addr),
      .dmem_wdata                 (dmem_wdata),
      .dmem_be                    (dmem_be),
      .dmem_ack                   (dmem_ack),
      .dmem_rdata                 (dmem_rdata),
      .wb_valid                   (wb_valid),
      .wb_we                      (wb_we),
      .wb_rd                      (wb_rd),
      .wb_data                    (wb_data),
      .misaligned                 (misaligned)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (!rst && wb_valid === 1'b1) wb_count++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic [2:0] f3);
      alu_result_from_execution  = a;
      read_data_2_from_execution = wd;
      immed_11_7_from_execution  = rd;
      mem_read  = mr;
      mem_write = mw;
      funct3    = f3;
      ex_valid  = 1'b1;
      step();
      ex_valid  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'h0) begin
         fails++; $display("FAIL reset_dmem: req=%0b we=%0b be=%h want 0 0 0", dmem_req, dmem_we, dmem_be); end
      checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
         fails++; $display("FAIL reset_dmem_data: addr=%h wdata=%h want 0 0", dmem_addr, dmem_wdata); end
      checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || misaligned !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0) begin
         fails++; $display("FAIL reset_wb: valid=%0b we=%0b mis=%0b rd=%0d data=%h want all 0", wb_valid, wb_we, misaligned, wb_rd, wb_data); end
      checks++; if (ex_ready !== 1'b1) begin
         fails++; $display("FAIL reset_ready: got %0b want 1", ex_ready); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_alu();
      issue(32'h1234_5678, 32'h0, 5'd5, 1'b0, 1'b0, 3'b000);
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h1234_5678 || wb_rd !== 5'd5 || wb_we !== 1'b1 || misaligned !== 1'b0) begin
         fails++; $display("FAIL alu_wb: valid=%0b data=%h rd=%0d we=%0b mis=%0b want 1 12345678 5 1 0", wb_valid, wb_data, wb_rd, wb_we, misaligned); end
      checks++; if (dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
         fails++; $display("FAIL alu_req: req=%0b ready=%0b want 0 1", dmem_req, ex_ready); end
      step();
      checks++; if (wb_valid !== 1'b0) begin
         fails++; $display("FAIL alu_pulse: wb_valid=%0b want 0", wb_valid); end
   endtask

   task automatic test_lb(input logic [2:0] f3, input logic [31:0] exp);
      issue(32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b0, f3);
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'h8 || dmem_we !== 1'b0) begin
         fails++; $display("FAIL lb_req: req=%0b addr=%h be=%h we=%0b want 1 100 8 0", dmem_req, dmem_addr, dmem_be, dmem_we); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'h8 || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
            fails++; $display("FAIL lb_wait%0d: req=%0b addr=%h be=%h ready=%0b wbv=%0b want 1 100 8 0 0", i, dmem_req, dmem_addr, dmem_be, ex_ready, wb_valid); end
      end
      dmem_ack = 1'b1;
      dmem_rdata = 32'h80AA_BBCC;
      step();
      dmem_ack = 1'b0;
      checks++; if (wb_valid !== 1'b1 || wb_data !== exp || wb_we !== 1'b1 || wb_rd !== 5'd7 || misaligned !== 1'b0) begin
         fails++; $display("FAIL lb_wb f3=%0d: valid=%0b data=%h we=%0b rd=%0d mis=%0b want 1 %h 1 7 0", f3, wb_valid, wb_data, wb_we, wb_rd, misaligned, exp); end
      checks++; if (dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
         fails++; $display("FAIL lb_done: req=%0b ready=%0b want 0 1", dmem_req, ex_ready); end
   endtask

   task automatic test_sh();
      checks++; if (ex_ready !== 1'b1) begin
         fails++; $display("FAIL sh_ready_before: got %0b want 1", ex_ready); end
      issue(32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b1, F3_H);
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'hC || dmem_wdata !== 32'hBEEF_BEEF || dmem_addr !== 32'h200) begin
         fails++; $display("FAIL sh_req: req=%0b we=%0b be=%h wdata=%h addr=%h want 1 1 c beefbeef 200", dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr); end
      checks++; if (ex_ready !== 1'b0) begin
         fails++; $display("FAIL sh_ready_low: got %0b want 0", ex_ready); end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || misaligned !== 1'b0 || wb_rd !== 5'd3) begin
         fails++; $display("FAIL sh_wb: valid=%0b we=%0b mis=%0b rd=%0d want 1 0 0 3", wb_valid, wb_we, misaligned, wb_rd); end
      checks++; if (ex_ready !== 1'b1 || dmem_req !== 1'b0) begin
         fails++; $display("FAIL sh_ready_after: ready=%0b req=%0b want 1 0", ex_ready, dmem_req); end
   endtask

   task automatic test_misaligned();
      issue(32'h0000_0101, 32'h0, 5'd9, 1'b1, 1'b0, F3_W);
      checks++; if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || misaligned !== 1'b1 || wb_we !== 1'b0 || wb_rd !== 5'd9 || ex_ready !== 1'b1) begin
         fails++; $display("FAIL mis_lw: req=%0b wbv=%0b mis=%0b we=%0b rd=%0d ready=%0b want 0 1 1 0 9 1", dmem_req, wb_valid, misaligned, wb_we, wb_rd, ex_ready); end
      issue(32'h0000_0201, 32'h1234_5678, 5'd1, 1'b0, 1'b1, F3_H);
      checks++; if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || misaligned !== 1'b1 || wb_we !== 1'b0) begin
         fails++; $display("FAIL mis_sh: req=%0b wbv=%0b mis=%0b we=%0b want 0 1 1 0", dmem_req, wb_valid, misaligned, wb_we); end
      step();
      checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
         fails++; $display("FAIL mis_after: wbv=%0b req=%0b want 0 0", wb_valid, dmem_req); end
   endtask

   task automatic test_reset_in_access();
      int start;
      start = wb_count;
      issue(32'h0000_0300, 32'h0, 5'd12, 1'b1, 1'b0, F3_W);
      checks++; if (dmem_req !== 1'b1) begin
         fails++; $display("FAIL rst_acc_req: got %0b want 1", dmem_req); end
      step();
      rst = 1'b1;
      step();
      checks++; if (dmem_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
         fails++; $display("FAIL rst_acc_drop: req=%0b ready=%0b wbv=%0b want 0 1 0", dmem_req, ex_ready, wb_valid); end
      rst = 1'b0;
      dmem_ack = 1'b1;
      dmem_rdata = 32'h5555_AAAA;
      step();
      dmem_ack = 1'b0;
      step();
      checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || wb_count != start || wb_data !== 32'h0) begin
         fails++; $display("FAIL rst_acc_stray: wbv=%0b req=%0b pulses=%0d data=%h want 0 0 0 0", wb_valid, dmem_req, wb_count - start, wb_data); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'h0000_0011; vals[1] = 32'hA5A5_0022; vals[2] = 32'h8000_0033;
      for (int i = 0; i < 3; i++) begin
         alu_result_from_execution = vals[i];
         immed_11_7_from_execution = 5'(i + 1);
         mem_read = 1'b0; mem_write = 1'b0;
         ex_valid = 1'b1;
         step();
         checks++; if (wb_valid !== 1'b1 || wb_data !== vals[i] || wb_rd !== 5'(i + 1) || ex_ready !== 1'b1) begin
            fails++; $display("FAIL b2b%0d: wbv=%0b data=%h rd=%0d ready=%0b want 1 %h %0d 1", i, wb_valid, wb_data, wb_rd, ex_ready, vals[i], i + 1); end
      end
      ex_valid = 1'b0;
      step();
      checks++; if (wb_valid !== 1'b0) begin
         fails++; $display("FAIL b2b_end: wbv=%0b want 0", wb_valid); end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic        mr;
      logic        mw;
      logic [2:0]  f3;
      int          delay;
      logic [31:0] rdata;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] exp_wdata;
      logic        exp_dwe;
      logic        exp_wbwe;
      logic [31:0] exp_data;
   } op_t;

   task automatic test_mix();
      op_t ops [8];
      int start;
      ops[0] = '{32'h402, 32'h0, 5'd4, 1'b1, 1'b0, F3_H, 2, 32'h8001_1234, 1'b0, 4'hC, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001};
      ops[1] = '{32'h400, 32'h0, 5'd0, 1'b1, 1'b0, F3_HU, 0, 32'h8001_F00D, 1'b0, 4'h3, 32'h0, 1'b0, 1'b1, 32'h0000_F00D};
      ops[2] = '{32'h501, 32'h1234_56A5, 5'd6, 1'b0, 1'b1, F3_B, 5, 32'h0, 1'b0, 4'h2, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0};
      ops[3] = '{32'h600, 32'h0, 5'd31, 1'b1, 1'b0, F3_W, 1, 32'hCAFE_BABE, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hCAFE_BABE};
      ops[4] = '{32'hFFFF_0000, 32'h0, 5'd2, 1'b0, 1'b0, 3'b000, 0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_0000};
      ops[5] = '{32'h602, 32'h0, 5'd8, 1'b1, 1'b0, F3_B, 4, 32'h0055_7F00, 1'b0, 4'h4, 32'h0, 1'b0, 1'b1, 32'h0000_0055};
      ops[6] = '{32'h700, 32'h1111_1111, 5'd10, 1'b1, 1'b1, F3_W, 0, 32'h2222_2222, 1'b0, 4'hF, 32'h1111_1111, 1'b0, 1'b1, 32'h2222_2222};
      ops[7] = '{32'h703, 32'h0, 5'd11, 1'b0, 1'b1, F3_W, 0, 32'h0, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      start = wb_count;
      for (int k = 0; k < 8; k++) begin
         if (ops[k].mis || !(ops[k].mr || ops[k].mw)) begin
            // an ack while idle must be ignored
            dmem_ack = !ops[k].mis;
            issue(ops[k].addr, ops[k].wd, ops[k].rd, ops[k].mr, ops[k].mw, ops[k].f3);
            dmem_ack = 1'b0;
            checks++; if (wb_valid !== 1'b1 || misaligned !== ops[k].mis || wb_we !== ops[k].exp_wbwe || wb_rd !== ops[k].rd || dmem_req !== 1'b0) begin
               fails++; $display("FAIL mix%0d_imm: wbv=%0b mis=%0b we=%0b rd=%0d req=%0b want 1 %0b %0b %0d 0", k, wb_valid, misaligned, wb_we, wb_rd, dmem_req, ops[k].mis, ops[k].exp_wbwe, ops[k].rd); end
            if (!ops[k].mis) begin
               checks++; if (wb_data !== ops[k].exp_data) begin
                  fails++; $display("FAIL mix%0d_data: got %h want %h", k, wb_data, ops[k].exp_data); end
            end
         end else begin
            issue(ops[k].addr, ops[k].wd, ops[k].rd, ops[k].mr, ops[k].mw, ops[k].f3);
            for (int d = 0; d <= ops[k].delay; d++) begin
               if (d > 0) step();
               checks++; if (dmem_req !== 1'b1 || dmem_addr !== (ops[k].addr & 32'hFFFF_FFFC) || dmem_be !== ops[k].be || dmem_we !== ops[k].exp_dwe || dmem_wdata !== ops[k].exp_wdata || wb_valid !== 1'b0) begin
                  fails++; $display("FAIL mix%0d_req c%0d: req=%0b addr=%h be=%h we=%0b wdata=%h wbv=%0b want 1 %h %h %0b %h 0", k, d, dmem_req, dmem_addr, dmem_be, dmem_we, dmem_wdata, wb_valid, ops[k].addr & 32'hFFFF_FFFC, ops[k].be, ops[k].exp_dwe, ops[k].exp_wdata); end
            end
            dmem_ack = 1'b1;
            dmem_rdata = ops[k].rdata;
            step();
            dmem_ack = 1'b0;
            checks++; if (wb_valid !== 1'b1 || wb_we !== ops[k].exp_wbwe || wb_rd !== ops[k].rd || misaligned !== 1'b0 || dmem_req !== 1'b0) begin
               fails++; $display("FAIL mix%0d_wb: wbv=%0b we=%0b rd=%0d mis=%0b req=%0b want 1 %0b %0d 0 0", k, wb_valid, wb_we, wb_rd, misaligned, dmem_req, ops[k].exp_wbwe, ops[k].rd); end
            if (ops[k].exp_wbwe) begin
               checks++; if (wb_data !== ops[k].exp_data) begin
                  fails++; $display("FAIL mix%0d_data: got %h want %h", k, wb_data, ops[k].exp_data); end
            end
         end
      end
      step();
      checks++; if (wb_count - start != 8 || wb_valid !== 1'b0) begin
         fails++; $display("FAIL mix_count: pulses=%0d wbv=%0b want 8 0", wb_count - start, wb_valid); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_lb(F3_B, 32'hFFFF_FF80);
      test_lb(F3_BU, 32'h0000_0080);
      test_sh();
      test_misaligned();
      test_reset_in_access();
      test_back_to_back();
      test_mix();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the five-stage RISC-V pipeline, the consumer of the execution stage's outputs. It accepts an instruction from execution over a valid/ready handshake and, for loads and stores, drives a single-outstanding request/acknowledge transaction on the data-memory port with byte-lane steering and load sign/zero extension. It then presents one result per instruction to write-back. Execution is stalled through `ex_ready` while a memory transaction is in flight.

## Interface
Parameters: none; XLEN is fixed at 32.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ex_valid`  in  1  execution presents an instruction
- `ex_ready`  out  1  stage accepts; transfer when `ex_valid && ex_ready`
- `alu_result_from_execution`  in  32  byte address (mem ops) or result (others)
- `read_data_2_from_execution`  in  32  store data
- `immed_11_7_from_execution`  in  5  destination register rd
- `mem_read`, `mem_write`  in  1 each  from controller; both high is illegal and treated as a load
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `dmem_req`  out  1  request, held until ack
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_be`  out  4  byte enables
- `dmem_ack`  in  1  completion; `dmem_rdata` valid in the same cycle
- `dmem_rdata`  in  32  read word
- `wb_valid`  out  1  one-cycle pulse per retired instruction
- `wb_we`  out  1  register write required (loads, ALU ops)
- `wb_rd`  out  5  destination register
- `wb_data`  out  32  write-back value
- `misaligned`  out  1  qualifies `wb_valid`; the access was suppressed

## Operation
- FSM states: IDLE, ACCESS. `ex_ready = (state == IDLE)`.
- IDLE, accepting a non-memory op: `wb_data` = ALU result, `wb_we` = 1, `wb_valid` next cycle, remain in IDLE.
- IDLE, accepting a load or store: register address, data, size, and rd.
  - If misaligned (H with addr[0] = 1, W with addr[1:0] ≠ 0): no request; next cycle `wb_valid` = 1, `misaligned` = 1, `wb_we` = 0; remain in IDLE.
  - Otherwise go to ACCESS.
- ACCESS: `dmem_req` = 1 with stable `dmem_addr`/`dmem_we`/`dmem_be`/`dmem_wdata` until `dmem_ack`. On ack: go to IDLE and pulse `wb_valid` next cycle.
  - Load: `wb_we` = 1, `wb_data` = extracted lane, sign- or zero-extended.
  - Store: `wb_we` = 0.
- Byte enables: B → `4'b0001 << addr[1:0]`; H → `4'b0011 << {addr[1],1'b0}`; W → `4'hF`.
- Store data: B replicates byte 0 to all four lanes; H replicates halfword 0 to both halves; W passes through.
- `dmem_ack` seen in IDLE is ignored.
- rd = 0 loads still access memory; `wb_rd` = 0 is passed through unchanged.
- Reset: state IDLE. `dmem_req`, `dmem_we`, `dmem_be`, `wb_valid`, `wb_we`, `misaligned` = 0. `dmem_addr`, `dmem_wdata`, `wb_rd`, `wb_data` = 0.
- Reset during ACCESS: `dmem_req` drops in the cycle after reset is sampled and the instruction is discarded; an ack arriving afterwards is ignored.

## Timing
- Non-memory or misaligned op: accepted at edge N, `wb_valid` high for cycle N+1 only.
- Load/store: accepted at edge N, `dmem_req` high from N+1; ack sampled at edge M; `wb_valid` high for cycle M+1; `ex_ready` high again from M+1.
- Zero-wait memory (ack in the first request cycle): 2 cycles from accept to `wb_valid`; throughput is one memory op per 2 cycles.
- Back-to-back non-memory ops sustain one per cycle.
- `ex_ready` is a registered function of state only, with no combinational path from `ex_valid` or `dmem_ack`.
- `wb_*` outputs are registered and valid only while `wb_valid` = 1.

## Structure
- Shared package `riscv_pkg`:
  - `funct3` load/store constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`)
  - `mem_state_t` enum `{IDLE, ACCESS}`
  - `XLEN` = 32
- One combinational sub-module, `load_store_align`: computes `be`, replicated `wdata`, the misalignment flag, and the extended load value from `addr[1:0]`, `funct3`, store data, and `rdata`. The FSM and registers stay in `memory_access`.

## Test plan
- ALU op, result 0x1234_5678, rd = 5 → `wb_valid` next cycle, `wb_data` = 0x1234_5678, `wb_rd` = 5, `wb_we` = 1, no `dmem_req`.
- LB at 0x103, `dmem_rdata` = 0x80AA_BBCC, ack after 3 wait cycles → `dmem_addr` = 0x100, `dmem_be` = 0x8; `wb_data` = 0xFFFF_FF80. The same access as LBU → `wb_data` = 0x0000_0080.
- SH at 0x202, data 0xDEAD_BEEF, zero-wait ack → `dmem_we` = 1, `dmem_be` = 0xC, `dmem_wdata` = 0xBEEF_BEEF; `wb_valid` with `wb_we` = 0; `ex_ready` low for exactly 1 cycle.
- LW at 0x101 → no `dmem_req`; `wb_valid` = 1 with `misaligned` = 1 and `wb_we` = 0 next cycle.
- Reset asserted during ACCESS with a stalled ack, then ack pulsed after reset → `dmem_req` = 0 and IDLE; no `wb_valid`; the stray ack causes no output.
- Random mix of ops under random ack delays (0–5 cycles) → `wb_valid` count equals accepted count, results arrive in order, and request signals stay stable until ack.
